imem_loader: RTL and testbench

//   Write-side companion to the clocked instruction ROM. Accepts a byte stream

---
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a valid/ready byte stream into little-endian words and writes them to instruction memory
//
// Ports:
//   clk       in   1            single clock, all logic on posedge
//   rst_n     in   1            asynchronous active-low reset
//   start     in   1            begin a load of len words (accepted in IDLE/DONE only)
//   len       in   AddrWidth+1  word count, sampled when start is accepted
//   in_valid  in   1            byte stream valid
//   in_data   in   8            byte stream data
//   in_ready  out  1            loader accepts a byte this cycle (LOAD)
//   wr_en     out  1            one-cycle write strobe (WRITE)
//   wr_addr   out  AddrWidth    word address of the write, held between strobes
//   wr_data   out  Width        assembled word, held between strobes
//   busy      out  1            high in LOAD or WRITE
//   cpu_hold  out  1            mirrors busy, keeps the core in reset while loading
//   done      out  1            load finished, held until the next accepted start
//   err       out  1            last accepted start had len > Depth
module imem_loader #(
    parameter int Width = 32,
    parameter int Depth = 32,
    localparam int AddrWidth = $clog2(Depth),
    localparam int BytesPerWord = Width / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AddrWidth:0]   len,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [AddrWidth-1:0] wr_addr,
    output logic [Width-1:0]     wr_data,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);
    // a one-byte word still needs a 1-bit byte counter
    localparam int BcW = BytesPerWord > 1 ? $clog2(BytesPerWord) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [AddrWidth:0]   len_q;
    logic [AddrWidth-1:0] word_idx;
    logic [BcW-1:0]       byte_cnt;
    logic [Width-1:0]     acc;
    logic [Width-1:0]     word_nx;
    logic                 start_ok;
    logic                 len_bad;
    logic                 xfer;
    logic                 last_byte;
    logic                 last_word;

    // partial word with the incoming byte dropped into its lane
    always_comb begin
        word_nx = acc;
        word_nx[8*byte_cnt +: 8] = in_data;
    end

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign len_bad   = len > (AddrWidth+1)'(Depth);
    assign xfer      = state == LOAD && in_valid;
    assign last_byte = byte_cnt == BcW'(BytesPerWord - 1);
    assign last_word = {1'b0, word_idx} == len_q - (AddrWidth+1)'(1);

    // Moore outputs: in_ready depends on state only, never on in_valid
    assign in_ready = state == LOAD;
    assign wr_en    = state == WRITE;
    assign busy     = in_ready || wr_en;
    assign cpu_hold = busy;
    assign done     = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            acc      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
        end else if (start_ok) begin
            len_q    <= len;
            err      <= len_bad;
            word_idx <= '0;
            byte_cnt <= '0;
            state    <= (len == '0 || len_bad) ? DONE : LOAD;
        end else if (xfer) begin
            acc      <= word_nx;
            byte_cnt <= last_byte ? '0 : byte_cnt + BcW'(1);
            if (last_byte) begin
                // capture into the output registers so they hold until the next word
                wr_data <= word_nx;
                wr_addr <= word_idx;
                state   <= WRITE;
            end
        end else if (state == WRITE) begin
            state    <= last_word ? DONE : LOAD;
            word_idx <= last_word ? word_idx : word_idx + AddrWidth'(1);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = $clog2(D);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          err;

    wr_t q[$];
    wr_t e;
    int  n_chk = 0;
    int  n_fail = 0;
    int  wr_cnt = 0;
    int  xfer_cnt = 0;

    imem_loader #(.Width(W), .Depth(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (in_valid && in_ready) xfer_cnt++;
        chk("cpu_hold_eq_busy", cpu_hold, busy);
        if (wr_en) begin
            wr_cnt++;
            chk("in_ready_in_write", in_ready, 0);
            n_chk++;
            assert (q.size() > 0) else begin
                n_fail++;
                $error("FAIL wr_unexpected: observed write addr %0h data %0h expected no write", wr_addr, wr_data);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", wr_addr, e.a);
                chk("wr_data", wr_data, e.d);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic push(input int a, input logic [W-1:0] d);
        wr_t x;
        x.a = AW'(a);
        x.d = d;
        q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int t = 0;
        in_valid = 1'b1;
        in_data = b;
        do begin
            ok = in_ready;
            tick();
            t++;
        end while (!ok && t < 50);
        chk("byte_accepted", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int w0;
        int x0;
        tick(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_done", done, 0);

        // two words streamed back to back
        do_start(2);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        push(0, 32'h04030201);
        push(1, 32'h08070605);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done();
        chk("t1_err", err, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_writes", wr_cnt, 2);
        chk("t1_sb_empty", q.size(), 0);

        // zero-length load
        w0 = wr_cnt;
        do_start(0);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        chk("t2_in_ready", in_ready, 0);
        tick(3);
        chk("t2_in_ready_later", in_ready, 0);
        chk("t2_no_write", wr_cnt, w0);

        // oversize length
        do_start(D + 1);
        chk("t3_done", done, 1);
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        tick(2);
        chk("t3_busy_later", busy, 0);
        chk("t3_err_held", err, 1);
        chk("t3_no_write", wr_cnt, w0);

        // in_valid toggling 1,0,1,0
        w0 = wr_cnt;
        x0 = xfer_cnt;
        do_start(1);
        chk("t4_err_cleared", err, 0);
        chk("t4_done_cleared", done, 0);
        push(0, 32'h44332211);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i * 8'h11));
            tick();
        end
        wait_done();
        chk("t4_xfers", xfer_cnt - x0, 4);
        chk("t4_writes", wr_cnt - w0, 1);

        // asynchronous reset in the middle of a load
        do_start(3);
        push(0, 32'h14131211);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
        chk("t5_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("t5_sb_empty", q.size(), 0);
        chk_all_zero("t5_after");
        do_start(1);
        push(0, 32'hDDCCBBAA);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_done();
        chk("t5_sb_empty2", q.size(), 0);

        // start pulse while busy is ignored
        w0 = wr_cnt;
        do_start(2);
        push(0, 32'h24232221);
        push(1, 32'h28272625);
        send_byte(8'h21);
        send_byte(8'h22);
        start = 1'b1;
        len = (AW+1)'(5);
        tick();
        start = 1'b0;
        chk("t6_busy", busy, 1);
        chk("t6_done", done, 0);
        for (int i = 3; i <= 8; i++) send_byte(8'(8'h20 + i));
        wait_done();
        chk("t6_err", err, 0);
        tick(4);
        chk("t6_writes", wr_cnt - w0, 2);
        chk("t6_sb_empty", q.size(), 0);
        chk("t6_done_held", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
